// File: rtl/clock_switch_pkg.sv
// clock_switch_pkg -- shared types and constants for the clock switch controller.
//   sw_state_e : controller FSM states (IDLE, SETTLE, DONE)
//   SEL_*      : clock source encodings driven on clk_sel / cur_sel
//   norm_sel   : folds the unused encoding 2'b11 onto the 1000 MHz source
package clock_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } sw_state_e;

  localparam logic [1:0] SEL_800  = 2'b00;
  localparam logic [1:0] SEL_500  = 2'b01;
  localparam logic [1:0] SEL_1000 = 2'b10;

  function automatic logic [1:0] norm_sel(input logic [1:0] sel);
    return (sel == 2'b11) ? SEL_1000 : sel;
  endfunction

endpackage

// File: rtl/clock_switch_ctrl_sync_2ff.sv
// sync_2ff -- 1-bit two-flop synchronizer, reset to 0, clocked by clk_aon.
// Only compiled when CLKSW_CLKOK_EN is defined (the sole user is the clk_ok path).
//   clk_aon : destination clock
//   rst_clk : asynchronous active-high reset
//   d       : asynchronous input
//   q       : synchronized output
`ifdef CLKSW_CLKOK_EN
module sync_2ff (
  input  logic clk_aon,
  input  logic rst_clk,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_aon or posedge rst_clk) begin
    if (rst_clk) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl -- sequences a glitch-free clock source switch from the
// always-on clock domain: loads the new select, waits a settle time, then
// pulses done and records the completed selection.
//
// Optional feature macro: CLKSW_CLKOK_EN
//   adds clk_ok (async, new clock running) and sticky err; SETTLE then also
//   waits for the synchronized clk_ok and gives up after TIMEOUT_CYC cycles.
//
// Ports:
//   clk_aon    in   always-on controller clock
//   rst_clk    in   asynchronous active-high reset
//   req_valid  in   switch request valid
//   req_sel    in   requested source (00=800, 01=500, 1x=1000)
//   req_ready  out  request accepted on req_valid & req_ready at a rising edge
//   scan_mode  in   DFT freeze: blocks new requests
//   clk_sel    out  registered select to the clock switch
//   cur_sel    out  last completed selection
//   busy       out  switch in progress (SETTLE or DONE)
//   done       out  one-cycle completion pulse
//   switch_cnt out  saturating count of real switches
//   clk_ok     in   (macro) new clock running, asynchronous
//   err        out  (macro) sticky settle timeout flag
module clock_switch_ctrl
  import clock_switch_pkg::*;
#(
  parameter int         SETTLE_CYC = 32,
  parameter logic [1:0] SEL_RST    = 2'b00
`ifdef CLKSW_CLKOK_EN
  , parameter int       TIMEOUT_CYC = 255
`endif
) (
  input  logic       clk_aon,
  input  logic       rst_clk,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  input  logic       scan_mode,
  output logic [1:0] clk_sel,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] switch_cnt
`ifdef CLKSW_CLKOK_EN
  , input  logic     clk_ok
  , output logic     err
`endif
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

  sw_state_e  state;
  logic [7:0] cnt;
  logic       accept;
  logic [1:0] sel_n;
  logic       settle_end;

  // Ready is combinational so a request held through DONE is taken on the
  // very first IDLE edge.
  assign req_ready = (state == ST_IDLE) & ~scan_mode & ~rst_clk;
  assign accept    = req_valid & req_ready;
  assign sel_n     = norm_sel(req_sel);

`ifdef CLKSW_CLKOK_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic       ok_sync;
  logic       settle_exit;
  logic [7:0] tcnt;

  sync_2ff u_clk_ok_sync (
    .clk_aon (clk_aon),
    .rst_clk (rst_clk),
    .d       (clk_ok),
    .q       (ok_sync)
  );

  assign settle_exit = (cnt == 8'd0) && ok_sync;
  // Timeout forces completion so the requester is never stuck.
  assign settle_end  = settle_exit || (tcnt == TO_LAST);
`else
  assign settle_end  = (cnt == 8'd0);
`endif

  always_ff @(posedge clk_aon or posedge rst_clk) begin
    if (rst_clk) begin
      state      <= ST_IDLE;
      clk_sel    <= SEL_RST;
      cur_sel    <= SEL_RST;
      busy       <= 1'b0;
      done       <= 1'b0;
      switch_cnt <= 8'd0;
      cnt        <= 8'd0;
`ifdef CLKSW_CLKOK_EN
      err        <= 1'b0;
      tcnt       <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
`ifdef CLKSW_CLKOK_EN
            err  <= 1'b0;
            tcnt <= 8'd0;
`endif
            if (sel_n == cur_sel) begin
              // Nothing to switch: report completion right away.
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              clk_sel <= sel_n;
              cnt     <= SETTLE_LD;
              state   <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          if (settle_end) begin
            state <= ST_DONE;
            done  <= 1'b1;
            if (switch_cnt != 8'hFF) switch_cnt <= switch_cnt + 8'd1;
`ifdef CLKSW_CLKOK_EN
            if (!settle_exit) err <= 1'b1;
`endif
          end
`ifdef CLKSW_CLKOK_EN
          else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        ST_DONE: begin
          cur_sel <= clk_sel;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
